// File: rtl/riscv_structures.sv
// riscv_structures: shared fetch types and instruction constants.
//   fetch_state_t : fetch sequencer states (RUN, HALT, FAULT)
//   fetch_entry_t : one buffered fetch {pc, instr}
//   INSTR_EBREAK  : encoding that stops fetching
//   INSTR_NOP     : canonical nop (addi x0, x0, 0)
package riscv_structures;
    typedef enum logic [1:0] {RUN, HALT, FAULT} fetch_state_t;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry synchronous FIFO of fetch entries.
//   clk, rst_n    : clock, synchronous active-low reset
//   push, wdata   : write wdata at the tail (caller guarantees room)
//   pop           : drop the head
//   flush         : empty the queue; wins over push, a same-cycle pop is moot
//   full, empty   : occupancy flags
//   head          : entry at the head, valid while !empty
module fetch_queue
    import riscv_structures::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wdata,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);
    localparam int AW = $clog2(DEPTH);
    fetch_entry_t mem_q [DEPTH];
    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    assign empty = wr_q == rd_q;
    // extra MSB differs only when the writer has lapped the reader
    assign full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign head = mem_q[rd_q[AW-1:0]];
    always_comb begin
        wr_d = flush ? wr_q : wr_q + {{AW{1'b0}}, push};
        rd_d = flush ? wr_q : rd_q + {{AW{1'b0}}, pop};
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_q[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: PC sequencer feeding decode through a small fetch queue.
//   clk, rst_n                 : clock, synchronous active-low reset
//   imem_addr, imem_data       : combinational-read instruction memory port
//   redirect_valid, redirect_pc: PC change request from execute
//   out_valid/out_ready        : handshake to decode, with out_instr/out_pc
//   halted, fault              : registered RUN/HALT/FAULT state flags
module instr_fetch_ctrl
    import riscv_structures::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_WORDS = 256,
    parameter int          DEPTH     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        halted,
    output logic        fault
);
    localparam logic [29:0] LIMIT = 30'(MEM_WORDS);
    fetch_state_t state_q, state_d;
    logic [31:0] pc_q, pc_d;
    fetch_entry_t hold_q, head, wdata;
    logic full, empty, pop, push, flush, in_range, can_push, misaligned;
    assign pop = !empty && out_ready;
    assign in_range = pc_q[31:2] < LIMIT;
    // a full queue still accepts a push when its head leaves this cycle
    assign can_push = state_q == RUN && (!full || pop);
    assign misaligned = redirect_pc[1:0] != 2'b00;
    assign wdata = '{pc: pc_q, instr: imem_data};
    always_comb begin
        state_d = state_q;
        pc_d = pc_q;
        push = 1'b0;
        flush = 1'b0;
        if (redirect_valid && state_q != FAULT) begin
            flush = 1'b1;
            state_d = misaligned ? FAULT : RUN;
            pc_d = misaligned ? pc_q : redirect_pc;
        end else if (can_push) begin
            push = in_range;
            state_d = !in_range ? FAULT : (imem_data == INSTR_EBREAK) ? HALT : RUN;
            pc_d = in_range ? pc_q + 32'd4 : pc_q;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            pc_q <= RESET_PC;
            hold_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q <= pc_d;
            if (pop) hold_q <= head;
        end
    end
    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk  (clk),
        .rst_n(rst_n),
        .push (push),
        .pop  (pop),
        .flush(flush),
        .wdata(wdata),
        .full (full),
        .empty(empty),
        .head (head)
    );
    assign imem_addr = pc_q;
    assign out_valid = !empty;
    // outputs keep the last consumed entry while the queue is empty
    assign out_instr = empty ? hold_q.instr : head.instr;
    assign out_pc = empty ? hold_q.pc : head.pc;
    assign halted = state_q == HALT;
    assign fault = state_q == FAULT;
endmodule
